// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch engine: FSM state encoding, command
// decoding with button priority, and the display-value width.
package stopwatch_pkg;

  localparam int MS_W = 39;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_LAP_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_START,
    CMD_LAP
  } cmd_e;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Only the highest-priority press in a cycle survives.
  function automatic cmd_e pick_cmd(input logic clear_p, input logic start_p, input logic lap_p);
    if (clear_p) return CMD_CLEAR;
    if (start_p) return CMD_START;
    if (lap_p)   return CMD_LAP;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF synchronizer, a debounce counter
// advanced on ms ticks, and a rising-edge pulse on each newly accepted high level.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CNT_W = width_of(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] stable_cnt;

  // NOTE: every register here uses <= so all flops sample pre-edge values; a blocking
  // assignment would collapse the two synchronizer stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      level       <= 1'b0;
      stable_cnt  <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (tick) begin
        if (stable_cnt == CNT_LAST) begin
          level       <= sync2;
          press_pulse <= sync2;
          stable_cnt  <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Millisecond stopwatch engine: prescaler, button conditioning, start/stop/lap/clear
// FSM, saturating count and blinking decimal points. Lap support: STOPWATCH_LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int         TICK_DIV    = 100_000,
  parameter int         MAX_MS      = 5_999_999,
  parameter int         DEBOUNCE_MS = 10,
  parameter int         BLINK_MS    = 500,
  parameter logic [7:0] DP_MASK     = 8'h28
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            btn_start,
  input  logic            btn_lap,
  input  logic            btn_clear,
  output logic [MS_W-1:0] elapsed_ms,
  output logic [7:0]      dec_points,
  output logic            running,
  output logic            overflow
);

  localparam int PS_W  = width_of(TICK_DIV);
  localparam int CNT_W = width_of(MAX_MS + 1);
  localparam int BL_W  = width_of(BLINK_MS);

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MS_MAX  = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MS_PRE  = CNT_W'(MAX_MS - 1);
  localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_MS - 1);

  logic [PS_W-1:0]  presc;
  logic             tick;
  logic             start_p;
  logic             lap_p;
  logic             clear_p;
  state_e           state;
  state_e           state_nx;
  cmd_e             cmd;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [CNT_W-1:0] shown;
  logic             ovf_nx;
  logic             snap_load;
  logic [BL_W-1:0]  blink_cnt;
  logic             dp_off;

  assign tick = (presc == PS_LAST);

  always_ff @(posedge clock) begin
    if (reset) presc <= '0;
    else       presc <= tick ? '0 : presc + 1'b1;
  end

  button_conditioner #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start (
    .clock(clock), .reset(reset), .tick(tick), .btn_raw(btn_start), .press_pulse(start_p)
  );

  button_conditioner #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_clear (
    .clock(clock), .reset(reset), .tick(tick), .btn_raw(btn_clear), .press_pulse(clear_p)
  );

`ifdef STOPWATCH_LAP_EN
  logic [CNT_W-1:0] snapshot;

  button_conditioner #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_lap (
    .clock(clock), .reset(reset), .tick(tick), .btn_raw(btn_lap), .press_pulse(lap_p)
  );

  always_ff @(posedge clock) begin
    if (reset)          snapshot <= '0;
    else if (snap_load) snapshot <= count;
  end

  assign shown = (state == ST_LAP_HOLD) ? snapshot : count;
`else
  logic unused_lap_path;

  assign lap_p           = 1'b0;
  assign unused_lap_path = btn_lap | snap_load;
  assign shown           = count;
`endif

  // NOTE: all outputs of this block get a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    ovf_nx    = 1'b0;
    snap_load = 1'b0;
    cmd       = pick_cmd(clear_p, start_p, lap_p);

    if ((state == ST_RUNNING || state == ST_LAP_HOLD) && tick && count != MS_MAX) begin
      count_nx = count + 1'b1;
      ovf_nx   = (count == MS_PRE);
    end

    // Reaching the limit overrides any button activity in the same cycle.
    if (ovf_nx) begin
      state_nx = ST_PAUSED;
    end else begin
      case (state)
        ST_IDLE:     if (cmd == CMD_START) state_nx = ST_RUNNING;
        ST_RUNNING: begin
          if (cmd == CMD_START) begin
            state_nx = ST_PAUSED;
          end else if (cmd == CMD_LAP) begin
            state_nx  = ST_LAP_HOLD;
            snap_load = 1'b1;
          end
        end
        ST_LAP_HOLD: begin
          if (cmd == CMD_LAP)        state_nx = ST_RUNNING;
          else if (cmd == CMD_START) state_nx = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (cmd == CMD_START) begin
            state_nx = ST_RUNNING;
          end else if (cmd == CMD_CLEAR) begin
            state_nx = ST_IDLE;
            count_nx = '0;
          end
        end
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      elapsed_ms <= '0;
      overflow   <= 1'b0;
      blink_cnt  <= '0;
      dp_off     <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      elapsed_ms <= MS_W'(shown);
      overflow   <= ovf_nx;
      // Each pause starts its blink with the points lit.
      if (state_nx == ST_PAUSED && state != ST_PAUSED) begin
        blink_cnt <= '0;
        dp_off    <= 1'b0;
      end else if (state == ST_PAUSED && tick) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt <= '0;
          dp_off    <= ~dp_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  assign running    = (state == ST_RUNNING) || (state == ST_LAP_HOLD);
  assign dec_points = (state == ST_PAUSED && dp_off) ? 8'h00 : DP_MASK;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: vector table, hand-written corner sequences
// and random button traffic, all compared every cycle against an event-level model.
module tb_stopwatch_core;

  localparam int         T   = 4;
  localparam int         D   = 2;
  localparam int         B   = 3;
  localparam int         M   = 20;
  localparam logic [7:0] DPM = 8'h28;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic [38:0] elapsed_ms;
  logic [7:0]  dec_points;
  logic        running;
  logic        overflow;

  stopwatch_core #(
    .TICK_DIV(T), .MAX_MS(M), .DEBOUNCE_MS(D), .BLINK_MS(B), .DP_MASK(DPM)
  ) dut (
    .clock(clock), .reset(reset), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .elapsed_ms(elapsed_ms), .dec_points(dec_points),
    .running(running), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the stopwatch as events in ms-tick time. Ticks are counted
  // arithmetically from the edge index since reset; a button level is accepted on the
  // D-th tick of an unbroken disagreement with the last accepted level.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_e;

  mstate_e    m_st;
  int         m_n, m_count, m_snap, m_pause_entry;
  longint     m_elapsed;
  bit         m_ovf;
  logic [7:0] m_dp;
  bit         m_h1[3], m_h2[3], m_level[3], m_pulse[3];
  int         m_mis[3];

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / T - a / T;
  endfunction

  task automatic model_edge();
    bit raw[3];
    bit tk, p_start, p_lap, p_clear;
    int cnt_pre;
    mstate_e prev;
    raw[0] = btn_start; raw[1] = btn_lap; raw[2] = btn_clear;
    if (reset) begin
      m_st = M_IDLE; m_n = 0; m_count = 0; m_snap = 0; m_elapsed = 0;
      m_ovf = 1'b0; m_dp = DPM; m_pause_entry = 0;
      for (int b = 0; b < 3; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_level[b] = 0; m_pulse[b] = 0; m_mis[b] = -1;
      end
      return;
    end
    tk      = (m_n % T) == T - 1;
    p_start = m_pulse[0];
    p_lap   = m_pulse[1] && LAP_EN;
    p_clear = m_pulse[2];
    m_elapsed = (m_st == M_LAP) ? m_snap : m_count;
    m_ovf   = 1'b0;
    prev    = m_st;
    cnt_pre = m_count;
    if ((m_st == M_RUN || m_st == M_LAP) && tk && m_count < M) begin
      m_count++;
      m_ovf = (m_count == M);
    end
    if (m_ovf) m_st = M_PAUSE;
    else if (p_clear) begin
      if (m_st == M_PAUSE) begin m_st = M_IDLE; m_count = 0; end
    end else if (p_start) begin
      case (m_st)
        M_IDLE, M_PAUSE: m_st = M_RUN;
        default:         m_st = M_PAUSE;
      endcase
    end else if (p_lap) begin
      if (m_st == M_RUN) begin m_st = M_LAP; m_snap = cnt_pre; end
      else if (m_st == M_LAP) m_st = M_RUN;
    end
    if (m_st == M_PAUSE && prev != M_PAUSE) m_pause_entry = m_n;
    m_dp = (m_st == M_PAUSE && ((ticks_in(m_pause_entry + 1, m_n) / B) % 2 == 1)) ? 8'h00 : DPM;
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = 0;
      if (m_h2[b] == m_level[b]) m_mis[b] = -1;
      else begin
        if (m_mis[b] < 0) m_mis[b] = m_n;
        if (tk && ticks_in(m_mis[b], m_n) == D) begin
          m_pulse[b] = m_h2[b]; m_level[b] = m_h2[b]; m_mis[b] = -1;
        end
      end
      m_h2[b] = m_h1[b];
      m_h1[b] = raw[b];
    end
    m_n++;
  endtask

  task automatic cycle();
    logic [63:0] exp_v;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    exp_v = {15'd0, 39'(m_elapsed), m_dp, (m_st == M_RUN || m_st == M_LAP), m_ovf};
    check("model {elapsed,dp,running,overflow}",
          {15'd0, elapsed_ms, dec_points, running, overflow}, exp_v);
    if (overflow === 1'b1) ovf_seen++;
  endtask

  task automatic do_reset();
    reset = 1'b1; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  // b = {clear, lap, start}
  task automatic press(input bit [2:0] b, input int hold, input int idle);
    {btn_clear, btn_lap, btn_start} = b;
    repeat (hold) cycle();
    {btn_clear, btn_lap, btn_start} = 3'b000;
    repeat (idle) cycle();
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && elapsed_ms < 39'(target); i++) cycle();
    if (elapsed_ms < 39'(target)) check("wait_elapsed timeout", 64'(elapsed_ms), 64'(target));
  endtask

  typedef struct {
    bit [2:0] btns;
    int       hold;
    int       idle;
    bit       exp_run;
    bit       chk_el;
    int       exp_el;
    bit       chk_dp;
    int       exp_ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [38:0] e1;

    vecs[0] = '{3'b001, 12, 12,  1'b1, 1'b0,  0, 1'b0, 0};  // IDLE start
    vecs[1] = '{3'b001, 12, 12,  1'b0, 1'b0,  0, 1'b0, 0};  // pause
    vecs[2] = '{3'b100, 12, 12,  1'b0, 1'b1,  0, 1'b1, 0};  // clear from PAUSED
    vecs[3] = '{3'b001, 12, 12,  1'b1, 1'b0,  0, 1'b0, 0};
    vecs[4] = '{3'b100, 12, 12,  1'b1, 1'b0,  0, 1'b0, 0};  // clear ignored while running
    vecs[5] = '{3'b000,  0, 100, 1'b0, 1'b1, 20, 1'b0, 1};  // saturate at MAX_MS
    vecs[6] = '{3'b101, 12, 12,  1'b0, 1'b1,  0, 1'b1, 0};  // clear beats start in PAUSED
    vecs[7] = '{3'b101, 12, 12,  1'b0, 1'b1,  0, 1'b1, 0};  // clear beats start in IDLE
    vecs[8] = '{3'b011, 12, 12,  1'b1, 1'b0,  0, 1'b0, 0};  // start beats lap
    vecs[9] = '{3'b011, 12, 12,  1'b0, 1'b0,  0, 1'b0, 0};

    do_reset();
    check("reset elapsed_ms", 64'(elapsed_ms), 64'd0);
    check("reset dec_points", 64'(dec_points), 64'(DPM));
    check("reset running",    64'(running), 64'd0);
    check("reset overflow",   64'(overflow), 64'd0);

    for (int i = 0; i < 10; i++) begin
      ovf_seen = 0;
      press(vecs[i].btns, vecs[i].hold, vecs[i].idle);
      check($sformatf("vec%0d running", i), 64'(running), 64'(vecs[i].exp_run));
      check($sformatf("vec%0d overflow pulses", i), 64'(ovf_seen), 64'(vecs[i].exp_ovf));
      if (vecs[i].chk_el) check($sformatf("vec%0d elapsed", i), 64'(elapsed_ms), 64'(vecs[i].exp_el));
      if (vecs[i].chk_dp) check($sformatf("vec%0d dec_points", i), 64'(dec_points), 64'(DPM));
    end

    // Bouncing start never survives the debounce window; a clean press toggles once.
    do_reset();
    for (int i = 0; i < 4; i++) press(3'b001, 1, 1);
    repeat (16) cycle();
    check("bounce running", 64'(running), 64'd0);
    check("bounce elapsed", 64'(elapsed_ms), 64'd0);
    press(3'b001, 12, 12);
    repeat (8) cycle();
    check("clean press running", 64'(running), 64'd1);

    // Lap freezes the display while the count keeps going; second lap resumes live view.
    do_reset();
    press(3'b001, 12, 0);
    run_until(1, 200);
    press(3'b010, 12, 12);
    e1 = elapsed_ms;
    repeat (4) cycle();
    check("lap display", 64'(elapsed_ms), LAP_EN ? 64'(e1) : 64'(e1 + 39'd1));
    check("lap running", 64'(running), 64'd1);
    press(3'b010, 12, 12);
    check("lap release live", 64'(elapsed_ms > e1 + 39'd4), 64'd1);

    // Reset mid-count.
    do_reset();
    press(3'b001, 12, 0);
    run_until(7, 200);
    check("reached 7 ms", 64'(elapsed_ms), 64'd7);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midreset elapsed", 64'(elapsed_ms), 64'd0);
    check("midreset running", 64'(running), 64'd0);
    check("midreset dec_points", 64'(dec_points), 64'(DPM));
    check("midreset overflow", 64'(overflow), 64'd0);

    // Random button traffic with occasional resets.
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) cycle();
        reset = 1'b0;
      end
      press(3'($urandom_range(0, 7)), $urandom_range(1, 16), $urandom_range(1, 20));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
